// File: rtl/oport_ovc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oport_ovc_ctrl_pkg
// Brief    : Shared types and sizing helpers for the output-port OVC controller
// Revision : 1.0 - initial release
// ============================================================================
package oport_ovc_ctrl_pkg;

    function automatic int credit_width(input int b);
        return $clog2(b + 1);
    endfunction

    // Shallow buffers cannot afford the nearly-full margin, so they allocate on not-full.
    function automatic int ovc_alloc_mode(input int v, input int b);
        return ((v == 1) || (b <= 4)) ? 1 : 0;
    endfunction

    localparam int CREDITw = credit_width(4);

    typedef enum logic [0:0] {
        OVC_FREE  = 1'b0,
        OVC_ALLOC = 1'b1
    } ovc_state_e;

    typedef struct packed {
        logic               avalable;
        logic               status;
        logic [CREDITw-1:0] credit;
        logic               full;
        logic               nearly_full;
        logic               empty;
    } ovc_info_t;

endpackage
`default_nettype wire

// File: rtl/oport_ovc_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ovc_rr_arbiter
// Brief    : N-wide round-robin arbiter, one-hot grant, registered pointer
// Revision : 1.0 - initial release
// ============================================================================
module ovc_rr_arbiter #(
    parameter int N = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // r_ptr names the highest-priority index; scan forward from it with wrap.
    always_comb begin
        o_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= N) j = j - N;
            if (!w_found && i_req[j]) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                w_idx    = PW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/oport_ovc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oport_ovc_ctrl
// Brief    : Output-port OVC allocator with per-OVC status and credit tracking
// Revision : 1.0 - initial release
// ============================================================================
module oport_ovc_ctrl
    import oport_ovc_ctrl_pkg::*;
#(
    parameter int V              = 4,
    parameter int B              = 4,
    parameter int NREQ           = 20,
    parameter int OVC_ALLOC_MODE = ovc_alloc_mode(V, B),
    parameter int CREDITw        = credit_width(B)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [V*CREDITw-1:0] credit_init_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*V-1:0]    cand_ovc_i,
    output logic                 grant_valid_o,
    output logic [NREQ-1:0]      grant_o,
    output logic [V-1:0]         grant_ovc_o,
    input  logic                 flit_wr_i,
    input  logic [V-1:0]         flit_vc_i,
    input  logic                 flit_tail_i,
    input  logic [V-1:0]         credit_in_i,
    output logic [V-1:0]         ovc_status_o,
    output logic [V*CREDITw-1:0] credit_o,
    output logic [V-1:0]         full_o,
    output logic [V-1:0]         nearly_full_o,
    output logic [V-1:0]         avail_o,
    output logic                 err_o
);

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_arb_gnt;
    logic            w_any;
    logic [V-1:0]    w_cand_sel;
    logic [V-1:0]    w_ovc_pick;
    logic [V-1:0]    w_err_set;

    logic            r_grant_valid;
    logic [NREQ-1:0] r_grant;
    logic [V-1:0]    r_grant_ovc;
    logic            r_err;

    // A requester granted last cycle is masked so a late-dropped req cannot double-win.
    always_comb begin
        w_elig = '0;
        for (int r = 0; r < NREQ; r++) begin
            w_elig[r] = req_i[r] & ~r_grant[r] & (|(cand_ovc_i[r*V +: V] & avail_o));
        end
    end

    assign w_any = |w_elig;

    ovc_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (reset),
        .i_req (w_elig),
        .i_en  (w_any),
        .o_gnt (w_arb_gnt)
    );

    always_comb begin
        w_cand_sel = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (w_arb_gnt[r]) w_cand_sel = w_cand_sel | cand_ovc_i[r*V +: V];
        end
    end

    // Isolate the lowest set bit of the winner's usable OVCs.
    logic [V-1:0] w_usable;
    assign w_usable   = w_cand_sel & avail_o;
    assign w_ovc_pick = w_usable & (~w_usable + V'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_valid <= 1'b0;
            r_grant       <= '0;
            r_grant_ovc   <= '0;
            r_err         <= 1'b0;
        end else begin
            r_grant_valid <= w_any;
            r_grant       <= w_any ? w_arb_gnt  : '0;
            r_grant_ovc   <= w_any ? w_ovc_pick : '0;
            if (|w_err_set) r_err <= 1'b1;
        end
    end

    assign grant_valid_o = r_grant_valid;
    assign grant_o       = r_grant;
    assign grant_ovc_o   = r_grant_ovc;
    assign err_o         = r_err;

    generate
        for (genvar v = 0; v < V; v++) begin : g_ovc
            ovc_state_e         r_state;
            logic [CREDITw-1:0] r_credit;
            logic [CREDITw-1:0] r_credit_max;
            logic               w_dec;
            logic               w_inc;
            logic               w_full;
            logic               w_nfull;

            assign w_dec   = flit_wr_i & flit_vc_i[v];
            assign w_inc   = credit_in_i[v];
            assign w_full  = (r_credit == '0);
            assign w_nfull = (r_credit <= CREDITw'(1));

            assign w_err_set[v] = (w_inc & ~w_dec & (r_credit >= r_credit_max)) |
                                  (w_dec & ~w_inc & w_full) |
                                  (w_dec & (r_state == OVC_FREE));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state      <= OVC_FREE;
                    r_credit     <= credit_init_i[v*CREDITw +: CREDITw];
                    r_credit_max <= credit_init_i[v*CREDITw +: CREDITw];
                end else begin
                    case (r_state)
                        OVC_FREE:  if (w_any && w_ovc_pick[v])  r_state <= OVC_ALLOC;
                        OVC_ALLOC: if (w_dec && flit_tail_i)    r_state <= OVC_FREE;
                        default:                                r_state <= OVC_FREE;
                    endcase
                    if (w_inc && !w_dec && (r_credit < r_credit_max)) begin
                        r_credit <= r_credit + CREDITw'(1);
                    end else if (w_dec && !w_inc && !w_full) begin
                        r_credit <= r_credit - CREDITw'(1);
                    end
                end
            end

            assign ovc_status_o[v]                   = (r_state == OVC_ALLOC);
            assign credit_o[v*CREDITw +: CREDITw]    = r_credit;
            assign full_o[v]                         = w_full;
            assign nearly_full_o[v]                  = w_nfull;
            assign avail_o[v] = (r_state == OVC_FREE) &
                                ((OVC_ALLOC_MODE != 0) ? ~w_full : ~w_nfull);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_oport_ovc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oport_ovc_ctrl
// Brief    : Directed self-checking bench for oport_ovc_ctrl (V=4, B=4, NREQ=20)
// Revision : 1.0 - initial release
// ============================================================================
module tb_oport_ovc_ctrl;

    localparam int V    = 4;
    localparam int B    = 4;
    localparam int NREQ = 20;
    localparam int CW   = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [V*CW-1:0]    credit_init_i;
    logic [NREQ-1:0]    req_i;
    logic [NREQ*V-1:0]  cand_ovc_i;
    logic               grant_valid_o;
    logic [NREQ-1:0]    grant_o;
    logic [V-1:0]       grant_ovc_o;
    logic               flit_wr_i;
    logic [V-1:0]       flit_vc_i;
    logic               flit_tail_i;
    logic [V-1:0]       credit_in_i;
    logic [V-1:0]       ovc_status_o;
    logic [V*CW-1:0]    credit_o;
    logic [V-1:0]       full_o;
    logic [V-1:0]       nearly_full_o;
    logic [V-1:0]       avail_o;
    logic               err_o;

    int n_vec  = 0;
    int n_miss = 0;

    oport_ovc_ctrl #(
        .V    (V),
        .B    (B),
        .NREQ (NREQ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .credit_init_i (credit_init_i),
        .req_i         (req_i),
        .cand_ovc_i    (cand_ovc_i),
        .grant_valid_o (grant_valid_o),
        .grant_o       (grant_o),
        .grant_ovc_o   (grant_ovc_o),
        .flit_wr_i     (flit_wr_i),
        .flit_vc_i     (flit_vc_i),
        .flit_tail_i   (flit_tail_i),
        .credit_in_i   (credit_in_i),
        .ovc_status_o  (ovc_status_o),
        .credit_o      (credit_o),
        .full_o        (full_o),
        .nearly_full_o (nearly_full_o),
        .avail_o       (avail_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cand(input int r, input logic [V-1:0] m);
        cand_ovc_i[r*V +: V] = m;
    endtask

    function automatic logic [CW-1:0] cred(input int v);
        return credit_o[v*CW +: CW];
    endfunction

    initial begin
        reset         = 1'b1;
        credit_init_i = 12'h924;
        req_i         = '0;
        cand_ovc_i    = '0;
        flit_wr_i     = 1'b0;
        flit_vc_i     = '0;
        flit_tail_i   = 1'b0;
        credit_in_i   = '0;
        tick();
        tick();
        reset = 1'b0;

        // Init
        chk("rst_status", 32'(ovc_status_o), 32'h0);
        chk("rst_credit", 32'(credit_o), 32'h924);
        chk("rst_avail", 32'(avail_o), 32'hF);
        chk("rst_gvalid", 32'(grant_valid_o), 32'h0);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_full", 32'(full_o), 32'h0);

        // Contention: r0, r5, r9 over OVC0/1
        set_cand(0, 4'b0011);
        set_cand(5, 4'b0011);
        set_cand(9, 4'b0011);
        req_i = (20'd1 << 0) | (20'd1 << 5) | (20'd1 << 9);
        tick();
        chk("c1_gvalid", 32'(grant_valid_o), 32'h1);
        chk("c1_grant", 32'(grant_o), 32'(20'd1 << 0));
        chk("c1_ovc", 32'(grant_ovc_o), 32'h1);
        chk("c1_status", 32'(ovc_status_o), 32'h1);
        req_i[0] = 1'b0;
        tick();
        chk("c2_grant", 32'(grant_o), 32'(20'd1 << 5));
        chk("c2_ovc", 32'(grant_ovc_o), 32'h2);
        chk("c2_status", 32'(ovc_status_o), 32'h3);
        req_i[5] = 1'b0;
        tick();
        chk("c3_gvalid", 32'(grant_valid_o), 32'h0);
        tick();
        chk("c4_gvalid", 32'(grant_valid_o), 32'h0);
        flit_wr_i   = 1'b1;
        flit_vc_i   = 4'b0001;
        flit_tail_i = 1'b1;
        tick();
        flit_wr_i   = 1'b0;
        flit_vc_i   = '0;
        flit_tail_i = 1'b0;
        chk("tail_gvalid", 32'(grant_valid_o), 32'h0);
        chk("tail_status", 32'(ovc_status_o), 32'h2);
        chk("tail_cred0", 32'(cred(0)), 32'h3);
        tick();
        chk("r9_grant", 32'(grant_o), 32'(20'd1 << 9));
        chk("r9_ovc", 32'(grant_ovc_o), 32'h1);
        req_i[9] = 1'b0;

        // Credit exhaustion on OVC2
        set_cand(3, 4'b0100);
        req_i[3] = 1'b1;
        tick();
        chk("r3_grant", 32'(grant_o), 32'(20'd1 << 3));
        chk("r3_ovc", 32'(grant_ovc_o), 32'h4);
        req_i[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flit_wr_i   = 1'b1;
            flit_vc_i   = 4'b0100;
            flit_tail_i = (i == 3);
            tick();
        end
        flit_wr_i   = 1'b0;
        flit_vc_i   = '0;
        flit_tail_i = 1'b0;
        chk("ex_cred2", 32'(cred(2)), 32'h0);
        chk("ex_full", 32'(full_o), 32'h4);
        chk("ex_nfull", 32'(nearly_full_o), 32'h4);
        chk("ex_status", 32'(ovc_status_o), 32'h3);
        chk("ex_avail", 32'(avail_o), 32'h8);
        chk("ex_err", 32'(err_o), 32'h0);
        req_i[3] = 1'b1;
        tick();
        chk("full_nogrant", 32'(grant_valid_o), 32'h0);
        credit_in_i = 4'b0100;
        tick();
        credit_in_i = '0;
        chk("cr_nogrant", 32'(grant_valid_o), 32'h0);
        chk("cr_avail", 32'(avail_o), 32'hC);
        chk("cr_cred2", 32'(cred(2)), 32'h1);
        tick();
        chk("cr_grant", 32'(grant_o), 32'(20'd1 << 3));
        chk("cr_ovc", 32'(grant_ovc_o), 32'h4);
        req_i[3] = 1'b0;

        // Simultaneous write and credit on OVC1
        flit_wr_i   = 1'b1;
        flit_vc_i   = 4'b0010;
        credit_in_i = 4'b0010;
        tick();
        flit_wr_i   = 1'b0;
        flit_vc_i   = '0;
        credit_in_i = '0;
        chk("sim_cred1", 32'(cred(1)), 32'h4);
        chk("sim_err", 32'(err_o), 32'h0);

        // Underflow on OVC2 (credit 1)
        flit_wr_i = 1'b1;
        flit_vc_i = 4'b0100;
        tick();
        chk("uf1_cred2", 32'(cred(2)), 32'h0);
        chk("uf1_err", 32'(err_o), 32'h0);
        tick();
        flit_wr_i = 1'b0;
        flit_vc_i = '0;
        chk("uf2_cred2", 32'(cred(2)), 32'h0);
        chk("uf2_err", 32'(err_o), 32'h1);
        tick();
        chk("uf_sticky", 32'(err_o), 32'h1);

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst2_err", 32'(err_o), 32'h0);
        chk("rst2_credit", 32'(credit_o), 32'h924);
        chk("rst2_status", 32'(ovc_status_o), 32'h0);

        // Overflow on OVC1 (credit at init)
        credit_in_i = 4'b0010;
        tick();
        credit_in_i = '0;
        chk("of_err", 32'(err_o), 32'h1);
        chk("of_cred1", 32'(cred(1)), 32'h4);
        tick();
        chk("of_sticky", 32'(err_o), 32'h1);

        // Move the pointer past r7 so a pointer reset is observable
        set_cand(7, 4'b0001);
        req_i[7] = 1'b1;
        tick();
        chk("r7_grant", 32'(grant_o), 32'(20'd1 << 7));
        req_i[7] = 1'b0;

        // Reset coincident with requests from r0 and r12, new credit_init
        reset         = 1'b1;
        credit_init_i = 12'h492;
        set_cand(0, 4'b0011);
        set_cand(12, 4'b0011);
        req_i = (20'd1 << 0) | (20'd1 << 12);
        tick();
        chk("rr_gvalid", 32'(grant_valid_o), 32'h0);
        chk("rr_credit", 32'(credit_o), 32'h492);
        chk("rr_status", 32'(ovc_status_o), 32'h0);
        chk("rr_err", 32'(err_o), 32'h0);
        reset         = 1'b0;
        credit_init_i = 12'h924;
        tick();
        chk("rr_grant0", 32'(grant_o), 32'(20'd1 << 0));
        chk("rr_ovc0", 32'(grant_ovc_o), 32'h1);
        chk("rr_credit_hold", 32'(credit_o), 32'h492);
        req_i[0] = 1'b0;
        tick();
        chk("rr_grant12", 32'(grant_o), 32'(20'd1 << 12));
        chk("rr_ovc12", 32'(grant_ovc_o), 32'h2);
        req_i = '0;
        flit_wr_i = 1'b1;
        flit_vc_i = 4'b0001;
        tick();
        flit_wr_i = 1'b0;
        flit_vc_i = '0;
        chk("nf_cred0", 32'(cred(0)), 32'h1);
        chk("nf_nfull", 32'(nearly_full_o), 32'h1);
        chk("nf_full", 32'(full_o), 32'h0);
        credit_in_i = 4'b0010;
        tick();
        credit_in_i = '0;
        chk("of2_err", 32'(err_o), 32'h1);
        chk("of2_cred1", 32'(cred(1)), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
